// File: rtl/wb_pkg.sv
// Shared types and decode helpers for the writeback select stage.
package wb_pkg;

    localparam int WB_SEL_W = 3;
    localparam int LD_F3_W  = 3;
    localparam int OFS_W    = 2;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU   = 3'b000,
        WB_MEM   = 3'b001,
        WB_AUIPC = 3'b010,
        WB_LUI   = 3'b011,
        WB_LINK  = 3'b101
    } wb_sel_e;

    typedef enum logic [LD_F3_W-1:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_funct3_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        DRAIN    = 2'b10
    } wb_state_e;

    // True when the load funct3 encodes a supported load width.
    function automatic logic ld_funct3_legal(input logic [LD_F3_W-1:0] f3);
        logic ok;
        case (f3)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when a legal load would straddle the 32-bit word.
    function automatic logic ld_misaligned(input logic [LD_F3_W-1:0] f3,
                                           input logic [OFS_W-1:0]   ofs);
        logic mis;
        case (f3)
            LD_LH, LD_LHU: mis = (ofs == 2'b11);
            LD_LW:         mis = (ofs != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Load data aligner: picks the addressed byte/halfword lane out of the
// memory word and sign- or zero-extends it to the datapath width.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]    rdata,
    input  logic [LD_F3_W-1:0] funct3,
    input  logic [OFS_W-1:0]   ofs,
    output logic [XLEN-1:0]    data
);

    logic [15:0] lane_s;

    // Shift the addressed lane to bit 0 and extend according to the load type.
    always_comb begin
        lane_s = 16'(rdata >> {ofs, 3'b000});
        data   = {XLEN{1'b0}};
        case (funct3)
            LD_LB: begin
                data      = {XLEN{lane_s[7]}};
                data[7:0] = lane_s[7:0];
            end
            LD_LH: begin
                data       = {XLEN{lane_s[15]}};
                data[15:0] = lane_s[15:0];
            end
            LD_LW: begin
                // Word loads always use the low word; on 64-bit cores bit 31 extends.
                data       = {XLEN{rdata[31]}};
                data[31:0] = rdata[31:0];
            end
            LD_LBU: begin
                data[7:0] = lane_s[7:0];
            end
            LD_LHU: begin
                data[15:0] = lane_s[15:0];
            end
            default: begin
                data = {XLEN{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: retires one instruction from MEM, chooses the
// register-file write data, waits for load responses and drives the
// register-file write port with registered outputs.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WB_SEL_W-1:0]   wb_sel,
    input  logic [LD_F3_W-1:0]    ld_funct3,
    input  logic [OFS_W-1:0]      byte_ofs,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rd_we,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [XLEN-1:0]       pc_imm,
    input  logic [XLEN-1:0]       pc_4,
    input  logic [XLEN-1:0]       imm,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  flush,
    output logic                  reg_we,
    output logic [REG_ADDR_W-1:0] reg_waddr,
    output logic [XLEN-1:0]       reg_write,
    output logic                  exc_sel,
    output logic                  exc_misalign
);

    wb_state_e state_r, state_nxt_s;

    // Load context captured at accept and consumed when the response arrives.
    logic [REG_ADDR_W-1:0] ld_rd_r;
    logic [LD_F3_W-1:0]    ld_funct3_r;
    logic [OFS_W-1:0]      ld_ofs_r;
    logic                  ld_rd_we_r;
    logic                  ld_latch_s;

    logic                  reg_we_r, reg_we_nxt_s;
    logic [REG_ADDR_W-1:0] reg_waddr_r, reg_waddr_nxt_s;
    logic [XLEN-1:0]       reg_write_r, reg_write_nxt_s;
    logic                  exc_sel_r, exc_sel_nxt_s;
    logic                  exc_mis_r, exc_mis_nxt_s;

    logic                  accept_s;
    logic                  sel_legal_s;
    logic                  is_load_s;
    logic [XLEN-1:0]       sel_data_s;
    logic [XLEN-1:0]       aligned_s;

    wb_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .rdata  (mem_rdata),
        .funct3 (ld_funct3_r),
        .ofs    (ld_ofs_r),
        .data   (aligned_s)
    );

    // Non-load source mux and legality of the select code.
    always_comb begin
        sel_data_s  = {XLEN{1'b0}};
        sel_legal_s = 1'b1;
        case (wb_sel)
            WB_ALU:   sel_data_s = alu_out;
            WB_MEM:   sel_data_s = {XLEN{1'b0}};
            WB_AUIPC: sel_data_s = pc_imm;
            WB_LUI:   sel_data_s = imm;
            WB_LINK:  sel_data_s = pc_4;
            default:  sel_legal_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; rd=x0 and rd_we=0 never produce a write.
    always_comb begin
        accept_s        = in_valid & (state_r == IDLE) & ~flush;
        is_load_s       = (wb_sel == WB_MEM);
        state_nxt_s     = state_r;
        ld_latch_s      = 1'b0;
        reg_we_nxt_s    = 1'b0;
        reg_waddr_nxt_s = reg_waddr_r;
        reg_write_nxt_s = reg_write_r;
        exc_sel_nxt_s   = 1'b0;
        exc_mis_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (!sel_legal_s) begin
                        exc_sel_nxt_s = 1'b1;
                    end else if (is_load_s) begin
                        if (!ld_funct3_legal(ld_funct3)) begin
                            exc_sel_nxt_s = 1'b1;
                        end else if (ld_misaligned(ld_funct3, byte_ofs)) begin
                            exc_mis_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = WAIT_MEM;
                            ld_latch_s  = 1'b1;
                        end
                    end else if (rd_we && (rd_addr != {REG_ADDR_W{1'b0}})) begin
                        reg_we_nxt_s    = 1'b1;
                        reg_waddr_nxt_s = rd_addr;
                        reg_write_nxt_s = sel_data_s;
                    end else begin
                        reg_we_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    // A response arriving with the flush is simply dropped.
                    state_nxt_s = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    state_nxt_s = IDLE;
                    if (ld_rd_we_r && (ld_rd_r != {REG_ADDR_W{1'b0}})) begin
                        reg_we_nxt_s    = 1'b1;
                        reg_waddr_nxt_s = ld_rd_r;
                        reg_write_nxt_s = aligned_s;
                    end else begin
                        reg_we_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = WAIT_MEM;
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Load context capture at the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_rd_r     <= {REG_ADDR_W{1'b0}};
            ld_funct3_r <= 3'b000;
            ld_ofs_r    <= 2'b00;
            ld_rd_we_r  <= 1'b0;
        end else if (ld_latch_s) begin
            ld_rd_r     <= rd_addr;
            ld_funct3_r <= ld_funct3;
            ld_ofs_r    <= byte_ofs;
            ld_rd_we_r  <= rd_we;
        end else begin
            ld_rd_r     <= ld_rd_r;
            ld_funct3_r <= ld_funct3_r;
            ld_ofs_r    <= ld_ofs_r;
            ld_rd_we_r  <= ld_rd_we_r;
        end
    end

    // Registered write port and exception pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_we_r    <= 1'b0;
            reg_waddr_r <= {REG_ADDR_W{1'b0}};
            reg_write_r <= {XLEN{1'b0}};
            exc_sel_r   <= 1'b0;
            exc_mis_r   <= 1'b0;
        end else begin
            reg_we_r    <= reg_we_nxt_s;
            reg_waddr_r <= reg_waddr_nxt_s;
            reg_write_r <= reg_write_nxt_s;
            exc_sel_r   <= exc_sel_nxt_s;
            exc_mis_r   <= exc_mis_nxt_s;
        end
    end

    assign in_ready     = (state_r == IDLE);
    assign reg_we       = reg_we_r;
    assign reg_waddr    = reg_waddr_r;
    assign reg_write    = reg_write_r;
    assign exc_sel      = exc_sel_r;
    assign exc_misalign = exc_mis_r;

endmodule
